// File: rtl/fpaddsub_align_stage2.sv
// Fine (0-15 bit) alignment shift of the smaller mantissa with sticky collection,
// registered behind a valid/ready handshake with a one-entry skid buffer.
// Optional sticky logic is built when FPADDSUB_ALIGN2_STICKY_EN is defined.
module fpaddsub_align_stage2 #(
  parameter int SIDE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Mmin_in,
  input  logic [3:0]        Shift,
  input  logic              StickyIn,
  input  logic [31:0]       Mmax_in,
  input  logic [SIDE_W-1:0] Side_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       Mmin_out,
  output logic              Sticky_out,
  output logic [31:0]       Mmax_out,
  output logic [SIDE_W-1:0] Side_out
);

  // State encoding is {main_v, skid_v}; 2'b01 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0]       mmin;
`ifdef FPADDSUB_ALIGN2_STICKY_EN
    logic              sticky;
`endif
    logic [31:0]       mmax;
    logic [SIDE_W-1:0] side;
  } payload_t;

  state_t   r_state;
  state_t   w_state_nxt;
  payload_t r_main;
  payload_t r_skid;
  payload_t w_in_word;

  logic        w_accept;
  logic        w_drain;
  logic        w_load_main_in;
  logic        w_load_main_skid;
  logic        w_load_skid;
  logic [31:0] w_a8;
  logic [31:0] w_a;
  logic [31:0] w_b2;
  logic [31:0] w_b;

  // Level A: shift by 8 then 4; level B: shift by 2 then 1.
  assign w_a8 = Shift[3] ? {8'b0, Mmin_in[31:8]} : Mmin_in;
  assign w_a  = Shift[2] ? {4'b0, w_a8[31:4]}    : w_a8;
  assign w_b2 = Shift[1] ? {2'b0, w_a[31:2]}     : w_a;
  assign w_b  = Shift[0] ? {1'b0, w_b2[31:1]}    : w_b2;

`ifdef FPADDSUB_ALIGN2_STICKY_EN
  logic w_sticky;
  // Each shifter level contributes exactly the bits it pushes below bit 0.
  assign w_sticky = StickyIn
                  | (Shift[3] & (|Mmin_in[7:0]))
                  | (Shift[2] & (|w_a8[3:0]))
                  | (Shift[1] & (|w_a[1:0]))
                  | (Shift[0] & w_b2[0]);
`else
  logic w_unused_sticky_in;
  assign w_unused_sticky_in = StickyIn;
`endif

  always_comb begin
    w_in_word        = '0;
    w_in_word.mmin   = w_b;
`ifdef FPADDSUB_ALIGN2_STICKY_EN
    w_in_word.sticky = w_sticky;
`endif
    w_in_word.mmax   = Mmax_in;
    w_in_word.side   = Side_in;
  end

  assign in_ready  = ~r_state[0];
  assign out_valid = r_state[1];
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_accept && w_drain) begin
          w_load_main_in = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_SKID;
        end
      end
      ST_SKID: begin
        if (w_drain) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: data registers are reset too, because zeroed outputs after reset are part of the contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_word;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_word;
      end
    end
  end

  assign Mmin_out = r_main.mmin;
  assign Mmax_out = r_main.mmax;
  assign Side_out = r_main.side;
`ifdef FPADDSUB_ALIGN2_STICKY_EN
  assign Sticky_out = r_main.sticky;
`else
  assign Sticky_out = 1'b0;
`endif

endmodule

// File: tb/tb_fpaddsub_align_stage2.sv
// Directed-vector bench for fpaddsub_align_stage2: shift/sticky values, skid
// backpressure ordering and asynchronous reset. Sticky expectations follow the macro.
module tb_fpaddsub_align_stage2;

  localparam int SIDE_W = 10;
`ifdef FPADDSUB_ALIGN2_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       Mmin_in;
  logic [3:0]        Shift;
  logic              StickyIn;
  logic [31:0]       Mmax_in;
  logic [SIDE_W-1:0] Side_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       Mmin_out;
  logic              Sticky_out;
  logic [31:0]       Mmax_out;
  logic [SIDE_W-1:0] Side_out;

  int n_total = 0;
  int n_bad   = 0;

  fpaddsub_align_stage2 #(.SIDE_W(SIDE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Mmin_in    (Mmin_in),
    .Shift      (Shift),
    .StickyIn   (StickyIn),
    .Mmax_in    (Mmax_in),
    .Side_in    (Side_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Mmin_out   (Mmin_out),
    .Sticky_out (Sticky_out),
    .Mmax_out   (Mmax_out),
    .Side_out   (Side_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] mmin, input logic [3:0] sh,
                       input logic st, input logic [31:0] mmax, input logic [SIDE_W-1:0] sd);
    in_valid = v;
    Mmin_in  = mmin;
    Shift    = sh;
    StickyIn = st;
    Mmax_in  = mmax;
    Side_in  = sd;
  endtask

  // Directed shift vectors: input, shift, sticky in, expected mantissa, expected sticky (macro on)
  typedef struct {
    logic [31:0] mmin;
    logic [3:0]  sh;
    logic        st;
    logic [31:0] exp_m;
    logic        exp_s;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_8001, 4'd1,  1'b0, 32'h0000_4000, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 4'd15, 1'b0, 32'h0001_FFFF, 1'b1};
    vecs[2] = '{32'h0001_0000, 4'd15, 1'b0, 32'h0000_0002, 1'b0};
    vecs[3] = '{32'h1234_5678, 4'd0,  1'b1, 32'h1234_5678, 1'b1};
    vecs[4] = '{32'h8000_0000, 4'd8,  1'b0, 32'h0080_0000, 1'b0};
    vecs[5] = '{32'h0000_001F, 4'd4,  1'b0, 32'h0000_0001, 1'b1};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_mmin",      64'(Mmin_out),  64'd0);
    rst = 1'b0;
    step();

    // Streaming: one new word per cycle, each visible one cycle after accept.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].mmin, vecs[i].sh, vecs[i].st, 32'hA5A5_0000 + 32'(i), SIDE_W'(10'h155 + i));
      step();
      check($sformatf("vec%0d_valid", i),  64'(out_valid),  64'd1);
      check($sformatf("vec%0d_mmin", i),   64'(Mmin_out),   64'(vecs[i].exp_m));
      check($sformatf("vec%0d_sticky", i), 64'(Sticky_out), 64'(vecs[i].exp_s & STICKY_ON));
      check($sformatf("vec%0d_mmax", i),   64'(Mmax_out),   64'(32'hA5A5_0000 + 32'(i)));
      check($sformatf("vec%0d_side", i),   64'(Side_out),   64'(SIDE_W'(10'h155 + i)));
      check($sformatf("vec%0d_ready", i),  64'(in_ready),   64'd1);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Backpressure: A to main, B to skid, C held upstream; then in-order drain.
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 4'd0, 1'b0, 32'hAAAA_0001, 10'h0A1);
    step();
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_mmin",  64'(Mmin_out),  64'h1111_1111);
    drive(1'b1, 32'h2222_2222, 4'd0, 1'b0, 32'hAAAA_0002, 10'h0B2);
    step();
    check("bp_skid_ready", 64'(in_ready), 64'd0);
    check("bp_hold_a",     64'(Mmin_out), 64'h1111_1111);
    drive(1'b1, 32'h3333_3333, 4'd0, 1'b0, 32'hAAAA_0003, 10'h0C3);
    step();
    check("bp_c_blocked", 64'(in_ready), 64'd0);
    check("bp_hold_a2",   64'(Mmin_out), 64'h1111_1111);
    check("bp_hold_side", 64'(Side_out), 64'h0A1);
    out_ready = 1'b1;
    step();
    check("bp_b_mmin",  64'(Mmin_out),  64'h2222_2222);
    check("bp_b_mmax",  64'(Mmax_out),  64'hAAAA_0002);
    check("bp_b_ready", 64'(in_ready),  64'd1);
    step();
    check("bp_c_mmin",  64'(Mmin_out),  64'h3333_3333);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Reset while in SKID, asserted between edges.
    out_ready = 1'b0;
    drive(1'b1, 32'h4444_4444, 4'd0, 1'b1, 32'hBBBB_0001, 10'h3FF);
    step();
    drive(1'b1, 32'h5555_5555, 4'd0, 1'b1, 32'hBBBB_0002, 10'h3FE);
    step();
    check("pre_rst_skid", 64'(in_ready), 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid",  64'(out_valid),  64'd0);
    check("arst_ready",  64'(in_ready),   64'd1);
    check("arst_mmin",   64'(Mmin_out),   64'd0);
    check("arst_mmax",   64'(Mmax_out),   64'd0);
    check("arst_side",   64'(Side_out),   64'd0);
    check("arst_sticky", 64'(Sticky_out), 64'd0);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_idle", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h0000_0100, 4'd2, 1'b0, 32'hCCCC_0001, 10'h077);
    step();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_mmin",  64'(Mmin_out),  64'h0000_0040);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("post_rst_single", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fpaddsub_align_stage2.md
# fpaddsub_align_stage2

Second alignment shift stage of the pipelined FP add/sub datapath. It sits directly downstream of the coarse (16-bit) alignment stage and consumes its smaller-mantissa output. It performs the remaining 0–15-bit right shift, accumulates the sticky bit from the discarded bits, and registers the result behind a valid/ready handshake with a one-entry skid buffer. The result feeds the mantissa add/sub stage.

## Interface
Parameters:
- SIDE_W, 10, width of the sideband bus carried alongside the mantissas (exponent, signs, opcode); passed through untouched.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- in_valid  input  1  upstream word is present.
- in_ready  output  1  stage can accept a word this cycle.
- Mmin_in  input  32  smaller mantissa after the coarse (16-bit) shift.
- Shift  input  4  residual shift amount, bits [3:0] of the full alignment shift.
- StickyIn  input  1  sticky from bits the coarse stage discarded.
- Mmax_in  input  32  larger mantissa, passed through.
- Side_in  input  SIDE_W  sideband, passed through.
- out_valid  output  1  output word is present.
- out_ready  input  1  downstream accepts the word this cycle.
- Mmin_out  output  32  Mmin_in >> Shift, zero-filled from the MSB.
- Sticky_out  output  1  OR of StickyIn and every bit shifted out below bit 0.
- Mmax_out  output  32  registered Mmax_in.
- Side_out  output  SIDE_W  registered Side_in.

## Operation
- Shift datapath (combinational, before the register): two levels.
  - Level A shifts by 8 and/or 4 per Shift[3:2].
  - Level B shifts by 2 and/or 1 per Shift[1:0].
  - Shift = 0 passes the word unchanged. The maximum shift is 15; bits [31:17] of the result are then 0.
- Sticky: the OR of Mmin_in[Shift-1:0] (0 when Shift = 0), ORed with StickyIn.
- Storage:
  - The main output register holds {Mmin, Sticky, Mmax, Side}.
  - A skid register has the same width, plus valid flags main_v (= out_valid) and skid_v.
- States, encoded by {main_v, skid_v}:
  - EMPTY 00 → FULL on accept.
  - FULL 10:
    - Stays FULL on accept together with drain.
    - Goes to EMPTY on drain with no accept.
    - Goes to SKID on accept while out_ready = 0.
  - SKID 11 → FULL on drain: the skid contents move to main, and the skid is cleared.
  - Combination 01 is illegal.
- Handshake rules:
  - in_ready = ~skid_v. It is registered and does not depend combinationally on out_ready.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - Order is strictly FIFO. No word is ever dropped or duplicated.
- Output stability: while out_valid = 1 and out_ready = 0, all outputs hold their values.

## Timing
- Latency is 1 cycle from accept to out_valid, when the stage is EMPTY or draining.
- Throughput is one word per cycle with out_ready held high.
- Reset values (asynchronous, so they take effect immediately on rst assertion):
  - out_valid = 0 and skid_v = 0, so in_ready = 1.
  - Mmin_out, Mmax_out, Side_out and Sticky_out = 0.
- Reset mid-operation: any words held in the main and skid registers are discarded. The first accept after rst deasserts behaves as from EMPTY.
- Simultaneous accept and drain:
  - In FULL, the new word replaces the main register.
  - In SKID, in_ready = 0, so no accept can occur.

## Configuration
- FPADDSUB_ALIGN2_STICKY_EN defined:
  - The sticky logic is built.
  - Sticky_out is registered as specified above.
- Macro undefined:
  - The shifted-out OR tree and StickyIn are ignored.
  - Sticky_out is constant 0.
  - Sticky storage is removed from both registers.
  - Shift, handshake and latency behaviour are unchanged.

## Test plan
- Fine shift with sticky: Mmin_in=0x0000_8001, Shift=1, StickyIn=0 → next cycle Mmin_out=0x0000_4000, Sticky_out=1, out_valid=1.
- Maximum shift: Mmin_in=0xFFFF_FFFF, Shift=15 → Mmin_out=0x0001_FFFF, Sticky_out=1. With Mmin_in=0x0001_0000, Shift=15 → 0x0000_0002, Sticky_out=0.
- Zero shift with StickyIn: Mmin_in=0x1234_5678, Shift=0, StickyIn=1 → Mmin_out=0x1234_5678, Sticky_out=1. Mmax_out and Side_out equal the inputs.
- Backpressure:
  - Stimulus: out_ready=0 while words A, B, C are offered on consecutive cycles.
  - A lands in main and B in the skid; in_ready goes 0, so C is held upstream.
  - Then out_ready=1 → A, B, C emerge in order on consecutive cycles, with in_ready back to 1 after B moves to main.
- Reset mid-operation: reach the SKID state, then assert rst asynchronously between edges → out_valid=0 and in_ready=1 immediately, with all data outputs 0. After release, a single word appears 1 cycle after its accept.
- Macro off: rerun the first scenario with FPADDSUB_ALIGN2_STICKY_EN undefined → Mmin_out=0x0000_4000, Sticky_out=0.
